lfsr_64bit_checker: RTL
=======================

LFSR_64BIT_CHECKER -- requirements
Module: lfsr_64bit_checker

Interface
REQ-001 Parameter ERR_THRESH, default 8, is the number of bit errors within one window that forces loss of lock (legal range 1..WINDOW).
REQ-002 Parameter WINDOW, default 256, is the number of checked bits per error-evaluation window (legal range 2..65535).
REQ-003 Port i_clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port i_reset, input, 1: synchronous, active-high reset.
REQ-005 Port i_valid, input, 1: i_bit is accepted on a rising edge only while i_valid=1.
REQ-006 Port i_bit, input, 1: received keystream bit.
REQ-007 Port i_clear_counts, input, 1: synchronous clear of o_err_count and o_bit_count.
REQ-008 Port o_locked, output, 1: high while in LOCKED.
REQ-009 Port o_err, output, 1: one-cycle pulse, high for the cycle after an accepted bit mismatches in LOCKED.
REQ-010 Port o_err_count, output, 32: total mismatches counted in LOCKED.
REQ-011 Port o_bit_count, output, 32: total bits checked in LOCKED.
REQ-012 Port o_lfsr, output, 64: current state register R.

Function
REQ-013 Sequence definition: s(k+64) = s(k+63) ^ s(k+3) ^ s(k+2) ^ s(k), matching the team's 64-bit keystream generator (right-shift register, taps 63/3/2/0, output bit 0).
REQ-014 The block SHALL have two states, ACQUIRE and LOCKED; reset enters ACQUIRE.
REQ-015 ACQUIRE, per accepted bit: R <= {i_bit, R[63:1]}; a 7-bit fill counter increments.
REQ-016 ACQUIRE: on the 64th accepted bit, if the resulting R is nonzero, go to LOCKED; if R is all-zero, clear the fill counter and stay in ACQUIRE.
REQ-017 o_locked SHALL rise the cycle after the 64th bit is accepted; the first checked bit is the next accepted bit.
REQ-018 LOCKED, per accepted bit: expected = R[63]^R[3]^R[2]^R[0]; R <= {expected, R[63:1]} (flywheel; i_bit never enters R).
REQ-019 LOCKED: on a mismatch (i_bit != expected), o_err=1 next cycle, o_err_count += 1, and window error count += 1.
REQ-020 LOCKED: every accepted bit increments o_bit_count and the window bit count.
REQ-021 o_err_count and o_bit_count SHALL saturate at 32'hFFFF_FFFF.
REQ-022 When the window bit count reaches WINDOW, both window counters SHALL clear to 0 after the current bit is processed.
REQ-023 When the window error count reaches ERR_THRESH, the block SHALL go to ACQUIRE (fill counter 0, window counters 0) on the same edge, and o_locked falls the next cycle.
REQ-024 Loss of lock SHALL take priority over a window rollover on the same bit.
REQ-025 The totals o_err_count and o_bit_count SHALL be kept across loss of lock.
REQ-026 i_clear_counts SHALL take priority over increments in the same cycle: both counts become 0, and o_err still pulses.
REQ-027 No state SHALL change and o_err SHALL be 0 in cycles with i_valid=0.
REQ-028 In ACQUIRE, o_err SHALL stay 0 and the counts SHALL not change.

Reset
REQ-029 i_reset=1 SHALL force, at the next edge: state ACQUIRE, R=0, fill and window counters 0, o_locked=0, o_err=0, o_err_count=0, o_bit_count=0.
REQ-030 Reset SHALL take priority over i_valid and i_clear_counts, and SHALL apply in any state, mid-acquisition or mid-window.

Verification
REQ-031 Feed 64 generator bits (seed 64'h1) then 1000 more bits -> o_locked=1 one cycle after bit 64, o_err never 1, o_bit_count=1000, o_err_count=0.
REQ-032 Locked on a clean stream, invert 3 isolated bits within one window (ERR_THRESH=8) -> 3 o_err pulses, o_err_count=3, lock held.
REQ-033 Locked, invert 8 bits within one window -> o_locked falls the cycle after the 8th error; re-feeding 64 correct bits relocks; o_err_count=8 is kept.
REQ-034 Feed 64 zero bits -> stays in ACQUIRE, o_locked=0; then feed 64 generator bits -> locks.
REQ-035 Locked, with i_clear_counts asserted in the same cycle as an accepted errored bit -> o_err=1, o_err_count=0, o_bit_count=0.
REQ-036 Assert i_reset after 40 acquisition bits, and separately mid-window in LOCKED -> all outputs 0, and 64 fresh bits are needed to lock.

Source files
------------

// File: rtl/lfsr_64bit_checker.sv
// ---------------------------------------------------------------------------
// lfsr_64bit_checker
//   Locks onto a received 64-bit LFSR keystream (taps 63/3/2/0, right shift,
//   output bit 0), then flywheels the register and counts bit mismatches.
//   Too many errors inside one evaluation window drops lock and the block
//   re-acquires from the incoming stream.
//
// Ports
//   i_clk          : clock, all logic on the rising edge
//   i_reset        : synchronous active-high reset
//   i_valid        : i_bit is accepted on an edge while high
//   i_bit          : received keystream bit
//   i_clear_counts : synchronous clear of both total counters
//   o_locked       : high while in LOCKED
//   o_err          : one-cycle pulse after an accepted mismatching bit
//   o_err_count    : saturating total of mismatches seen in LOCKED
//   o_bit_count    : saturating total of bits checked in LOCKED
//   o_lfsr         : current 64-bit state register
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ACQUIRE  | shifting received bits into R, waiting for 64 fresh bits
// LOCKED   | R flywheels on its own feedback; received bits are compared
// ---------------------------------------------------------------------------
module lfsr_64bit_checker #(
    parameter int unsigned ERR_THRESH = 8,
    parameter int unsigned WINDOW     = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_bit,
    input  logic        i_clear_counts,
    output logic        o_locked,
    output logic        o_err,
    output logic [31:0] o_err_count,
    output logic [31:0] o_bit_count,
    output logic [63:0] o_lfsr
);

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_LOCKED  = 1'b1
    } state_e;

    // 17 bits so the window counters can reach WINDOW (up to 65535) + 1
    localparam logic [16:0] WIN_L = 17'(WINDOW);
    localparam logic [16:0] THR_L = 17'(ERR_THRESH);
    localparam logic [31:0] SAT   = 32'hFFFF_FFFF;

    state_e      state_q,    state_d;
    logic [63:0] lfsr_q,     lfsr_d;
    logic [6:0]  fill_q,     fill_d;
    logic [16:0] win_bits_q, win_bits_d;
    logic [16:0] win_errs_q, win_errs_d;
    logic        err_q,      err_d;
    logic [31:0] err_cnt_q,  err_cnt_d;
    logic [31:0] bit_cnt_q,  bit_cnt_d;

    logic        fb;
    logic        mismatch;
    logic [16:0] win_bits_inc;
    logic [16:0] win_errs_inc;

    assign fb           = lfsr_q[63] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
    assign mismatch     = i_bit ^ fb;
    assign win_bits_inc = win_bits_q + 17'd1;
    assign win_errs_inc = win_errs_q + {16'd0, mismatch};

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        fill_d     = fill_q;
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (i_valid) begin
            case (state_q)
                ST_ACQUIRE: begin
                    lfsr_d = {i_bit, lfsr_q[63:1]};
                    if (fill_q == 7'd63) begin
                        // an all-zero fill is the LFSR lock-up state; refill
                        fill_d = 7'd0;
                        if (lfsr_d != 64'd0) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        fill_d = fill_q + 7'd1;
                    end
                end
                ST_LOCKED: begin
                    lfsr_d = {fb, lfsr_q[63:1]};
                    err_d  = mismatch;
                    if (bit_cnt_q != SAT) begin
                        bit_cnt_d = bit_cnt_q + 32'd1;
                    end
                    if (mismatch && (err_cnt_q != SAT)) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                    end
                    // loss of lock wins over a window rollover on the same bit
                    if (win_errs_inc == THR_L) begin
                        state_d    = ST_ACQUIRE;
                        fill_d     = 7'd0;
                        win_bits_d = 17'd0;
                        win_errs_d = 17'd0;
                    end else if (win_bits_inc == WIN_L) begin
                        win_bits_d = 17'd0;
                        win_errs_d = 17'd0;
                    end else begin
                        win_bits_d = win_bits_inc;
                        win_errs_d = win_errs_inc;
                    end
                end
                default: state_d = ST_ACQUIRE;
            endcase
        end

        if (i_clear_counts) begin
            err_cnt_d = 32'd0;
            bit_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_ACQUIRE;
            lfsr_q     <= 64'd0;
            fill_q     <= 7'd0;
            win_bits_q <= 17'd0;
            win_errs_q <= 17'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= 32'd0;
            bit_cnt_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            fill_q     <= fill_d;
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_locked    = (state_q == ST_LOCKED);
    assign o_err       = err_q;
    assign o_err_count = err_cnt_q;
    assign o_bit_count = bit_cnt_q;
    assign o_lfsr      = lfsr_q;

endmodule
